// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if: fetch, stack and ALU-issue signals of the sequencer
interface instruction_sequencer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        stk_req;
  logic        stk_push;
  logic [31:0] stk_wdata;
  logic        stk_ack;
  logic [31:0] stk_rdata;
  logic [31:0] ope;
  logic [31:0] immidiate_data;
  logic [7:0]  modrm;
  logic        exec_valid;
  logic [31:0] eip;
  logic        illegal;
  modport master (
    output mem_req, mem_addr, stk_req, stk_push, stk_wdata,
    output ope, immidiate_data, modrm, exec_valid, eip, illegal,
    input  mem_ack, mem_rdata, stk_ack, stk_rdata
  );
  modport slave (
    input  mem_req, mem_addr, stk_req, stk_push, stk_wdata,
    input  ope, immidiate_data, modrm, exec_valid, eip, illegal,
    output mem_ack, mem_rdata, stk_ack, stk_rdata
  );
endinterface

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: byte fetch, decode and ALU issue with call/ret stack sequencing
module instruction_sequencer #(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
  input logic clock,
  input logic reset,
  instruction_sequencer_if.master bus
);
  typedef enum logic [2:0] {FETCH_OP, FETCH_MODRM, FETCH_IMM, EXEC, STACK, HALT} state_e;
  state_e      state_q;
  logic [31:0] eip_q, imm_q, stk_wdata_q;
  logic [23:0] acc_q;
  logic [7:0]  op_q, ope_q, modrm_q, rd;
  logic [1:0]  cnt_q;
  logic        stk_push_q, illegal_q, no_opnd, has_imm;
  assign rd      = bus.mem_rdata;
  assign no_opnd = rd == 8'h55 || rd == 8'h5d || rd == 8'hc3;
  assign has_imm = rd == 8'hb8 || rd == 8'he8;
  // requests are gated by reset so none is visible while reset is held
  assign bus.mem_req        = !reset && (state_q == FETCH_OP || state_q == FETCH_MODRM || state_q == FETCH_IMM);
  assign bus.stk_req        = !reset && state_q == STACK;
  assign bus.exec_valid     = !reset && state_q == EXEC;
  assign bus.mem_addr       = eip_q;
  assign bus.eip            = eip_q;
  assign bus.stk_push       = stk_push_q;
  assign bus.stk_wdata      = stk_wdata_q;
  assign bus.ope            = {24'h0, ope_q};
  assign bus.immidiate_data = imm_q;
  assign bus.modrm          = modrm_q;
  assign bus.illegal        = illegal_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FETCH_OP;
      eip_q       <= RESET_EIP;
      ope_q       <= '0;
      imm_q       <= '0;
      modrm_q     <= '0;
      stk_wdata_q <= '0;
      acc_q       <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      stk_push_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        FETCH_OP: if (bus.mem_ack) begin
          eip_q     <= eip_q + 32'd1;
          op_q      <= rd;
          cnt_q     <= '0;
          illegal_q <= !(no_opnd || has_imm || rd == 8'h89);
          state_q   <= no_opnd ? EXEC : rd == 8'h89 ? FETCH_MODRM : has_imm ? FETCH_IMM : HALT;
          if (no_opnd) begin
            ope_q   <= rd;
            imm_q   <= '0;
            modrm_q <= '0;
          end
        end
        FETCH_MODRM: if (bus.mem_ack) begin
          eip_q   <= eip_q + 32'd1;
          ope_q   <= op_q;
          imm_q   <= '0;
          modrm_q <= rd;
          state_q <= EXEC;
        end
        FETCH_IMM: if (bus.mem_ack) begin
          eip_q <= eip_q + 32'd1;
          cnt_q <= cnt_q + 2'd1;
          acc_q <= {rd, acc_q[23:8]};
          if (cnt_q == 2'd3) begin
            ope_q   <= op_q;
            imm_q   <= {rd, acc_q};
            modrm_q <= '0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          state_q    <= (op_q == 8'he8 || op_q == 8'hc3) ? STACK : FETCH_OP;
          stk_push_q <= op_q == 8'he8;
          if (op_q == 8'he8) stk_wdata_q <= eip_q;
        end
        STACK: if (bus.stk_ack) begin
          eip_q   <= stk_push_q ? eip_q + imm_q : bus.stk_rdata;
          state_q <= FETCH_OP;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: ISA-level reference model feeding exec/stack scoreboards
module tb_instruction_sequencer;
  logic clk = 1'b0, rst0 = 1'b1, rst1 = 1'b1;
  always #5 clk = ~clk;
  instruction_sequencer_if b0();
  instruction_sequencer_if b1();
  instruction_sequencer dut0 (.clock(clk), .reset(rst0), .bus(b0));
  instruction_sequencer #(.RESET_EIP(32'hFFFF_FFFF)) dut1 (.clock(clk), .reset(rst1), .bus(b1));

  typedef struct { logic [7:0] op; logic [31:0] imm; logic [7:0] modrm; logic [31:0] eip; int cyc; } exec_t;
  typedef struct { logic push; logic [31:0] data; } stk_t;
  exec_t       exp_q[$];
  stk_t        exp_stk[$];
  int          mem_wq[$], stk_wq[$];
  logic [31:0] pop_q[$], ret_stack[$];
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] m_e;
  int          m_t, cyc = 0, n_cmp = 0, n_err = 0;

  always @(posedge clk) cyc <= rst0 ? 0 : cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // memory and stack responders; waits come from queues filled by the model
  initial begin
    int mw, sw;
    mw = -1; sw = -1;
    b0.mem_ack = 0; b0.mem_rdata = 0; b0.stk_ack = 0; b0.stk_rdata = 0;
    forever begin
      @(negedge clk);
      if (b0.mem_req) begin
        if (mw < 0) mw = mem_wq.size() != 0 ? mem_wq.pop_front() : 0;
        b0.mem_ack   = mw == 0;
        b0.mem_rdata = mem.exists(b0.mem_addr) ? mem[b0.mem_addr] : 8'h90;
        mw--;
      end else begin
        mw = -1;
        b0.mem_ack   = $urandom_range(0, 3) == 0;
        b0.mem_rdata = 8'($urandom);
      end
      if (b0.stk_req) begin
        if (sw < 0) sw = stk_wq.size() != 0 ? stk_wq.pop_front() : 0;
        b0.stk_ack   = sw == 0;
        b0.stk_rdata = 32'h0;
        if (sw == 0 && !b0.stk_push && pop_q.size() != 0) b0.stk_rdata = pop_q.pop_front();
        sw--;
      end else begin
        sw = -1;
        b0.stk_ack   = $urandom_range(0, 3) == 0;
        b0.stk_rdata = $urandom;
      end
    end
  end

  // monitor: compares every ALU issue and stack completion against the scoreboards
  initial begin
    exec_t e;
    stk_t  s;
    forever begin
      @(negedge clk);
      #1;
      if (b0.exec_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL exec_unexpected: ope %h issued, required no issue", b0.ope);
        end else begin
          e = exp_q.pop_front();
          chk("ope", b0.ope, {24'h0, e.op});
          chk("immidiate_data", b0.immidiate_data, e.imm);
          chk("modrm", {24'h0, b0.modrm}, {24'h0, e.modrm});
          chk("exec_eip", b0.eip, e.eip);
          chk("exec_cycle", cyc + 1, e.cyc);
        end
      end
      if (b0.stk_req) chk("req_exclusive", 32'(b0.mem_req), 0);
      if (b0.stk_req && b0.stk_ack) begin
        if (exp_stk.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL stack_unexpected: push %0d, required no stack op", b0.stk_push);
        end else begin
          s = exp_stk.pop_front();
          chk("stk_push", 32'(b0.stk_push), 32'(s.push));
          if (s.push) chk("stk_wdata", b0.stk_wdata, s.data);
        end
      end
    end
  end

  // reference model: executes the instruction as it lays its bytes into memory
  task automatic put(logic [7:0] v, int w);
    int ww;
    ww = w < 0 ? int'($urandom_range(0, 2)) : w;
    mem[m_e] = v;
    mem_wq.push_back(ww);
    m_t += ww + 1;
    m_e = m_e + 32'd1;
  endtask

  task automatic issue(logic [7:0] op, logic [31:0] imm, logic [7:0] mr, logic [31:0] rv, int w);
    exec_t e;
    int sw;
    logic [31:0] r;
    logic hi;
    hi = op == 8'hb8 || op == 8'he8;
    put(op, w);
    if (op == 8'h89) put(mr, w);
    if (hi) for (int k = 0; k < 4; k++) put(imm[8*k +: 8], w);
    e.op = op; e.imm = hi ? imm : 32'h0; e.modrm = op == 8'h89 ? mr : 8'h0;
    e.eip = m_e; e.cyc = m_t;
    exp_q.push_back(e);
    m_t++;
    if (op == 8'he8 || op == 8'hc3) begin
      sw = w < 0 ? int'($urandom_range(0, 2)) : w;
      stk_wq.push_back(sw);
      m_t += sw + 1;
      if (op == 8'he8) begin
        exp_stk.push_back('{1'b1, m_e});
        ret_stack.push_back(m_e);
        m_e = m_e + imm;
      end else begin
        r = ret_stack.size() != 0 ? ret_stack.pop_back() : rv;
        exp_stk.push_back('{1'b0, r});
        pop_q.push_back(r);
        m_e = r;
      end
    end
  endtask

  task automatic start();
    rst0 = 1'b1;
    exp_q.delete(); exp_stk.delete(); mem_wq.delete(); stk_wq.delete();
    pop_q.delete(); ret_stack.delete(); mem.delete();
    m_e = 32'h0; m_t = 1;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(b0.mem_req), 0);
    chk("rst_stk_req", 32'(b0.stk_req), 0);
    chk("rst_eip", b0.eip, 32'h0);
    chk("rst_ope", b0.ope, 32'h0);
    chk("rst_imm", b0.immidiate_data, 32'h0);
    chk("rst_modrm", {24'h0, b0.modrm}, 32'h0);
    chk("rst_stk_wdata", b0.stk_wdata, 32'h0);
    chk("rst_flags", {29'h0, b0.exec_valid, b0.illegal, b0.stk_push}, 32'h0);
    rst0 = 1'b0;
    #1 chk("first_mem_req", 32'(b0.mem_req), 1);
  endtask

  task automatic drain(int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_stk.size() != 0) && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (n >= bound) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d exec and %0d stack pending, required 0", exp_q.size(), exp_stk.size());
    end
    #1;
  endtask

  task automatic halt_check(logic [31:0] fe, int bound);
    int n, quiet;
    n = 0; quiet = 0;
    drain(bound);
    while (!b0.illegal && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("illegal", 32'(b0.illegal), 1);
    chk("halt_eip", b0.eip, fe);
    repeat (20) begin
      @(negedge clk);
      if (b0.mem_req || b0.stk_req || b0.exec_valid) quiet++;
    end
    chk("halt_quiet", quiet, 0);
    chk("halt_eip_frozen", b0.eip, fe);
  endtask

  initial begin
    logic [7:0]  ops [6];
    logic [7:0]  op;
    logic [31:0] imm, fresh;
    ops = '{8'h55, 8'h5d, 8'hc3, 8'h89, 8'hb8, 8'he8};
    b1.mem_ack = 0; b1.mem_rdata = 0; b1.stk_ack = 0; b1.stk_rdata = 0;
    start(); issue(8'h55, 0, 0, 0, 0); issue(8'h89, 0, 8'he5, 0, 0); issue(8'h5d, 0, 0, 0, 0);
    put(8'h90, 0); release_rst(); halt_check(32'h5, 500);
    start(); issue(8'hb8, 32'h1234_5678, 0, 0, 2); put(8'h90, 2); release_rst(); halt_check(32'h6, 500);
    start(); issue(8'hc3, 0, 0, 32'hDEAD_BEEF, 0); release_rst(); drain(100);
    chk("ret_mem_addr", b0.mem_addr, 32'hDEAD_BEEF);
    start(); issue(8'hc3, 0, 0, 32'h100, 0); issue(8'he8, 32'hFFFF_FFFB, 0, 0, 0); release_rst(); drain(100);
    chk("call_eip", b0.eip, 32'h100);
    for (int r = 0; r < 3; r++) begin
      start();
      fresh = 32'hF000_0000;
      for (int i = 0; i < 60; i++) begin
        op = ops[$urandom_range(0, 5)];
        imm = op == 8'he8 ? fresh - (m_e + 32'd5) : $urandom;
        issue(op, imm, 8'($urandom), fresh, -1);
        if (op == 8'he8 || op == 8'hc3) fresh = fresh - 32'h1000;
      end
      put(8'h90, -1);
      release_rst();
      halt_check(m_e, 5000);
    end
    // second instance: reset vector at the top of memory, abort mid-immediate
    repeat (2) @(posedge clk);
    #1;
    chk("r1_eip", b1.eip, 32'hFFFF_FFFF);
    chk("r1_mem_req_rst", 32'(b1.mem_req), 0);
    rst1 = 1'b0;
    #1 chk("r1_mem_req", 32'(b1.mem_req), 1);
    @(negedge clk) begin b1.mem_ack = 1; b1.mem_rdata = 8'hb8; end
    @(posedge clk) #1 chk("r1_wrap", b1.eip, 32'h0);
    @(negedge clk) b1.mem_rdata = 8'h78;
    @(posedge clk) #1 chk("r1_eip1", b1.eip, 32'h1);
    @(negedge clk) b1.mem_rdata = 8'h56;
    @(posedge clk) #1 chk("r1_eip2", b1.eip, 32'h2);
    @(negedge clk) begin b1.mem_rdata = 8'h34; rst1 = 1'b1; end
    @(posedge clk) #1;
    chk("r1_abort_eip", b1.eip, 32'hFFFF_FFFF);
    chk("r1_abort_ope", b1.ope, 32'h0);
    chk("r1_abort_imm", b1.immidiate_data, 32'h0);
    @(posedge clk) #1 chk("r1_late_ack_eip", b1.eip, 32'hFFFF_FFFF);
    b1.mem_ack = 0; rst1 = 1'b0;
    #1 chk("r1_restart_addr", b1.mem_addr, 32'hFFFF_FFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Fetch/decode/issue controller for the byte-coded x86-subset core. It fetches instruction bytes over a byte-wide memory handshake and assembles the opcode, ModRM byte and little-endian 32-bit immediate. It presents one decoded instruction to the ALU per execute cycle as `ope` and `immidiate_data`. It also owns `eip` and sequences `call`/`ret` through a stack handshake.

## Interface
Parameters:
- `RESET_EIP`, default 32'h0000_0000: `eip` value after reset.

Ports:
- `clock` in 1: single system clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_req` out 1: byte fetch request.
- `mem_addr` out 32: fetch address; always equals `eip`.
- `mem_ack` in 1: byte transfer completes on a rising edge with `mem_req && mem_ack`.
- `mem_rdata` in 8: fetched byte, sampled on the completing edge.
- `stk_req` out 1: stack operation request.
- `stk_push` out 1: 1 = push, 0 = pop; valid while `stk_req` is high.
- `stk_wdata` out 32: push data (the return address).
- `stk_ack` in 1: stack operation completes on a rising edge with `stk_req && stk_ack`.
- `stk_rdata` in 32: pop data, sampled on the completing edge.
- `ope` out 32: zero-extended opcode `{24'h0, opcode}` for the ALU.
- `immidiate_data` out 32: assembled immediate for the ALU.
- `modrm` out 8: ModRM byte for `0x89`; 0 otherwise.
- `exec_valid` out 1: one-cycle pulse; ALU inputs are valid this cycle.
- `eip` out 32: current instruction pointer.
- `illegal` out 1: sticky flag; an undecodable opcode was fetched.

## Operation
- States: FETCH_OP, FETCH_MODRM, FETCH_IMM, EXEC, STACK, HALT.
- `mem_req` is 1 exactly in FETCH_OP, FETCH_MODRM and FETCH_IMM.
- `mem_addr = eip`, held stable until the ack.
- Each completed byte fetch increments `eip` by 1, modulo 2^32 (0xFFFF_FFFF wraps to 0).
- FETCH_OP decode on the completing edge:
  - `0x55`, `0x5d`, `0xc3`: no operands; go to EXEC.
  - `0x89`: go to FETCH_MODRM (1 byte), then EXEC.
  - `0xb8`, `0xe8`: go to FETCH_IMM.
  - Any other opcode: set `illegal` = 1, go to HALT.
- FETCH_IMM: a 2-bit byte counter collects 4 bytes.
  - Byte k lands in `immidiate_data[8k+7:8k]` (little-endian).
  - After byte 3, go to EXEC.
- EXEC lasts exactly 1 cycle and asserts `exec_valid` = 1.
  - `ope`, `modrm` and `immidiate_data` update on the edge entering EXEC.
  - They hold until the next entry to EXEC.
  - `immidiate_data` = 0 and `modrm` = 0 for instructions that lack those operands.
- Leaving EXEC:
  - `0xe8`: go to STACK as a push with `stk_wdata = eip` (the address after the immediate).
  - `0xc3`: go to STACK as a pop.
  - All other opcodes: go to FETCH_OP.
- STACK: `stk_req` = 1 until the ack; then go to FETCH_OP.
  - Push completion: `eip <= eip + immidiate_data` (32-bit wrap; a negative rel32 works by two's complement).
  - Pop completion: `eip <= stk_rdata`.
- HALT: all requests stay 0 and `eip` is frozen. Only `reset` exits HALT.
- `stk_req` and `mem_req` are never asserted in the same cycle.
- `mem_ack` or `stk_ack` arriving while the matching request is low is ignored.

## Timing
- Reset values:
  - State FETCH_OP, `eip = RESET_EIP`.
  - `ope`, `immidiate_data`, `modrm`, `stk_wdata` = 0.
  - `exec_valid`, `illegal`, `stk_push` = 0.
  - `mem_req` and `stk_req` = 0 while `reset` is high.
- `mem_req` is first asserted in the first cycle after `reset` falls.
- Reset mid-fetch or mid-stack aborts the operation. There are no partial `eip` or operand updates, and a late ack after reset is ignored.
- Requests and decoded outputs come from registered state. An ack may arrive in the same cycle the request first rises (zero-wait).
- Minimum cycles per instruction with zero-wait acks:
  - `0x55`, `0x5d`: 2.
  - `0xc3`: 3.
  - `0x89`: 3.
  - `0xb8`: 6.
  - `0xe8`: 7.
- Each wait cycle on an ack adds exactly 1 cycle.
- `exec_valid` rises no earlier than the cycle after the last operand byte completes.

## Test plan
- Program `55 89 E5 5D` from `eip` 0 with zero-wait acks:
  - `exec_valid` pulses at cycles 2, 5 and 7.
  - `ope` = 0x55, then 0x89 with `modrm` = 0xE5, then 0x5d.
  - `eip` = 4 at the end.
- `B8 78 56 34 12` with 2 wait cycles per byte:
  - `immidiate_data` = 0x1234_5678.
  - `exec_valid` occurs 16 cycles after `reset` falls.
  - `eip` = 5.
- `E8 FB FF FF FF` at `eip` 0x100:
  - Push with `stk_wdata` = 0x105.
  - After `stk_ack`, `eip` = 0x100.
- `C3` with `stk_rdata` = 0xDEAD_BEEF:
  - `stk_push` = 0 during the request.
  - After the ack, `mem_addr` = 0xDEAD_BEEF.
- Opcode `0x90`:
  - `illegal` = 1, then no `mem_req`, `stk_req` or `exec_valid` for 20 cycles.
  - Reset clears `illegal` and restores `eip` = `RESET_EIP`.
- `RESET_EIP` = 0xFFFF_FFFF, program `B8` followed by an imm byte at 0:
  - `eip` wraps to 0 after the first fetch.
  - Reset asserted in the 3rd imm byte → `eip` = 0xFFFF_FFFF, and `ope` / `immidiate_data` stay 0.
